spi_controller_iomem_fifo: RTL

Memory-mapped SPI/dual/quad controller for the riscv iomem bus, with TX and RX byte FIFOs so the CPU can queue bursts without polling per byte. It has a programmable SCK divider, NUM_CS independent chip selects, and per-transfer mode (1/2/4-bit) selection. The shift engine is internal. The block sits between the SoC iomem decoder and the flash/target SPI pins.

---
 rtl/spi_controller_iomem_fifo_if.sv | 12 +
 rtl/spi_controller_iomem_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller_iomem_fifo_if.sv
// iomem bus bundle between the SoC decoder (master) and the SPI controller (slave).
interface spi_controller_iomem_fifo_if;
    logic        sel;
    logic [3:0]  wstrb;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (output sel, wstrb, addr, wdata, input ready, rdata);
    modport slave  (input sel, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/spi_controller_iomem_fifo.sv
// Memory-mapped single/dual/quad SPI controller with TX/RX byte FIFOs.
// CTRL at 0x00, DATA (push TX / pop RX) at 0x04, STATUS at 0x08.
module spi_controller_iomem_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int NUM_CS     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    spi_controller_iomem_fifo_if.slave bus,
    output logic [NUM_CS-1:0]          spi_cs_n,
    output logic                       spi_clk,
    input  logic [3:0]                 spi_data_in,
    output logic [3:0]                 spi_data_out,
    output logic [3:0]                 spi_data_enable
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO  = PW'(0);
    localparam logic [31:0]   CS_MASK   = ((32'd1 << NUM_CS) - 32'd1) << 16;
    localparam logic [31:0]   CTRL_MASK = 32'h0100_FFF3 | CS_MASK;
    localparam logic [7:0]    ADDR_CTRL   = 8'h00;
    localparam logic [7:0]    ADDR_DATA   = 8'h04;
    localparam logic [7:0]    ADDR_STATUS = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT_LO = 2'd1,
        ST_SHIFT_HI = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Mode 3 is an alias of single mode; normalise once so the engine sees 0/1/2 only.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        case (m)
            2'd1:    return 2'd1;
            2'd2:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] bits_for(input logic [1:0] m);
        case (m)
            2'd1:    return 4'd4;
            2'd2:    return 4'd2;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] top_bits(input logic [7:0] b, input logic [1:0] m);
        case (m)
            2'd1:    return {2'b00, b[7:6]};
            2'd2:    return b[7:4];
            default: return {3'b000, b[7]};
        endcase
    endfunction

    function automatic logic [7:0] shift_tx(input logic [7:0] b, input logic [1:0] m);
        case (m)
            2'd1:    return {b[5:0], 2'b00};
            2'd2:    return {b[3:0], 4'b0000};
            default: return {b[6:0], 1'b0};
        endcase
    endfunction

    function automatic logic [7:0] sample_rx(input logic [7:0] r, input logic [3:0] din, input logic [1:0] m);
        case (m)
            2'd1:    return {r[5:0], din[1:0]};
            2'd2:    return {r[3:0], din};
            default: return {r[6:0], din[1]};
        endcase
    endfunction

    state_t             state_r, next_state_s;
    logic [31:0]        ctrl_r;
    logic [7:0]         tx_mem_r [FIFO_DEPTH];
    logic [7:0]         rx_mem_r [FIFO_DEPTH];
    logic [PW-1:0]      tx_wptr_r, tx_rptr_r, rx_wptr_r, rx_rptr_r;
    logic [CW-1:0]      tx_count_r, rx_count_r;
    logic               tx_ovf_r, rx_ovf_r;
    logic [7:0]         tx_sh_r, rx_sh_r, div_r, div_cnt_r;
    logic [1:0]         mode_r;
    logic [3:0]         bits_left_r, spi_data_out_r;
    logic               spi_clk_r;
    logic [NUM_CS-1:0]  spi_cs_n_r;
    logic               wr_s, rd_s, flush_s, tx_nonempty_s, rx_nonempty_s;
    logic               tx_push_req_s, tx_push_s, tx_pop_s, rx_push_req_s, rx_push_s, rx_pop_s;
    logic               load_s, lo_tick_s, hi_tick_s, done_s;
    logic [1:0]         mode_s;
    logic [31:0]        status_s, rdata_s;

    assign wr_s          = bus.sel & (bus.wstrb != 4'b0000);
    assign rd_s          = bus.sel & (bus.wstrb == 4'b0000);
    assign flush_s       = wr_s & (bus.addr == ADDR_STATUS) & bus.wdata[2];
    assign tx_nonempty_s = (tx_count_r != CNT_ZERO);
    assign rx_nonempty_s = (rx_count_r != CNT_ZERO);
    assign mode_s        = norm_mode(ctrl_r[1:0]);

    // A full FIFO still accepts a push when the same cycle pops an entry.
    assign tx_push_req_s = wr_s & (bus.addr == ADDR_DATA) & bus.wstrb[0];
    assign tx_pop_s      = load_s;
    assign tx_push_s     = tx_push_req_s & ((tx_count_r != FULL_CNT) | tx_pop_s);
    assign rx_pop_s      = rd_s & (bus.addr == ADDR_DATA) & rx_nonempty_s;
    assign rx_push_req_s = done_s & ctrl_r[24];
    assign rx_push_s     = rx_push_req_s & ((rx_count_r != FULL_CNT) | rx_pop_s);

    // Next-state and per-cycle engine strobes.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        lo_tick_s    = 1'b0;
        hi_tick_s    = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tx_nonempty_s) begin
                    load_s       = 1'b1;
                    next_state_s = ST_SHIFT_LO;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SHIFT_LO: begin
                if (div_cnt_r == 8'd0) begin
                    lo_tick_s    = 1'b1;
                    next_state_s = ST_SHIFT_HI;
                end else begin
                    next_state_s = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_HI: begin
                if (div_cnt_r == 8'd0) begin
                    hi_tick_s    = 1'b1;
                    next_state_s = (bits_left_r != 4'd1) ? ST_SHIFT_LO : ST_DONE;
                end else begin
                    next_state_s = ST_SHIFT_HI;
                end
            end
            ST_DONE: begin
                done_s       = 1'b1;
                next_state_s = ST_IDLE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= next_state_s;
    end

    // Shift engine: byte/mode/divider are latched at load so CTRL edits only affect later bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_sh_r        <= 8'd0;
            rx_sh_r        <= 8'd0;
            mode_r         <= 2'd0;
            div_r          <= 8'd0;
            div_cnt_r      <= 8'd0;
            bits_left_r    <= 4'd0;
            spi_clk_r      <= 1'b0;
            spi_data_out_r <= 4'd0;
        end else if (load_s) begin
            tx_sh_r        <= tx_mem_r[tx_rptr_r];
            rx_sh_r        <= 8'd0;
            mode_r         <= mode_s;
            div_r          <= ctrl_r[15:8];
            div_cnt_r      <= ctrl_r[15:8];
            bits_left_r    <= bits_for(mode_s);
            spi_data_out_r <= top_bits(tx_mem_r[tx_rptr_r], mode_s);
        end else if (lo_tick_s) begin
            div_cnt_r <= div_r;
            spi_clk_r <= 1'b1;
            rx_sh_r   <= sample_rx(rx_sh_r, spi_data_in, mode_r);
        end else if (hi_tick_s) begin
            div_cnt_r   <= div_r;
            spi_clk_r   <= 1'b0;
            tx_sh_r     <= shift_tx(tx_sh_r, mode_r);
            bits_left_r <= bits_left_r - 4'd1;
            if (bits_left_r != 4'd1) spi_data_out_r <= top_bits(shift_tx(tx_sh_r, mode_r), mode_r);
        end else if ((state_r == ST_SHIFT_LO) || (state_r == ST_SHIFT_HI)) begin
            div_cnt_r <= div_cnt_r - 8'd1;
        end
    end

    // CTRL register with per-byte strobes; chip selects follow it one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_r     <= 32'd0;
            spi_cs_n_r <= {NUM_CS{1'b1}};
        end else begin
            spi_cs_n_r <= ~ctrl_r[16 +: NUM_CS];
            if (wr_s && (bus.addr == ADDR_CTRL)) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.wstrb[i]) ctrl_r[8*i +: 8] <= bus.wdata[8*i +: 8] & CTRL_MASK[8*i +: 8];
                end
            end
        end
    end

    // TX FIFO; a flush empties it but leaves the byte already in the engine alone.
    always_ff @(posedge clk) begin
        if (reset || flush_s) begin
            tx_wptr_r  <= PTR_ZERO;
            tx_rptr_r  <= PTR_ZERO;
            tx_count_r <= CNT_ZERO;
        end else begin
            if (tx_push_s) begin
                tx_mem_r[tx_wptr_r] <= bus.wdata[7:0];
                tx_wptr_r           <= tx_wptr_r + PTR_ONE;
            end
            if (tx_pop_s) tx_rptr_r <= tx_rptr_r + PTR_ONE;
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_count_r <= tx_count_r + CNT_ONE;
                2'b01:   tx_count_r <= tx_count_r - CNT_ONE;
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

    // RX FIFO, filled from the engine when a byte completes.
    always_ff @(posedge clk) begin
        if (reset || flush_s) begin
            rx_wptr_r  <= PTR_ZERO;
            rx_rptr_r  <= PTR_ZERO;
            rx_count_r <= CNT_ZERO;
        end else begin
            if (rx_push_s) begin
                rx_mem_r[rx_wptr_r] <= rx_sh_r;
                rx_wptr_r           <= rx_wptr_r + PTR_ONE;
            end
            if (rx_pop_s) rx_rptr_r <= rx_rptr_r + PTR_ONE;
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + CNT_ONE;
                2'b01:   rx_count_r <= rx_count_r - CNT_ONE;
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end

    // Sticky overflow flags, cleared by writing 1 to STATUS.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ovf_r <= 1'b0;
            rx_ovf_r <= 1'b0;
        end else begin
            if (tx_push_req_s && !tx_push_s) tx_ovf_r <= 1'b1;
            else if (wr_s && (bus.addr == ADDR_STATUS) && bus.wdata[0]) tx_ovf_r <= 1'b0;
            if (rx_push_req_s && !rx_push_s) rx_ovf_r <= 1'b1;
            else if (wr_s && (bus.addr == ADDR_STATUS) && bus.wdata[1]) rx_ovf_r <= 1'b0;
        end
    end

    // STATUS word and combinational read mux.
    always_comb begin
        status_s            = 32'd0;
        status_s[31]        = (state_r != ST_IDLE) | tx_nonempty_s;
        status_s[16 +: CW]  = rx_count_r;
        status_s[8 +: CW]   = tx_count_r;
        status_s[1]         = rx_ovf_r;
        status_s[0]         = tx_ovf_r;
        case (bus.addr)
            ADDR_CTRL:   rdata_s = ctrl_r;
            ADDR_DATA:   rdata_s = {rx_nonempty_s, 23'd0, rx_nonempty_s ? rx_mem_r[rx_rptr_r] : 8'd0};
            ADDR_STATUS: rdata_s = status_s;
            default:     rdata_s = 32'd0;
        endcase
    end

    assign bus.ready       = 1'b1;
    assign bus.rdata       = rdata_s;
    assign spi_cs_n        = spi_cs_n_r;
    assign spi_clk         = spi_clk_r;
    assign spi_data_out    = spi_data_out_r;
    assign spi_data_enable = ctrl_r[7:4];
endmodule
